// File: rtl/decode_scan.sv
// ---------------------------------------------------------------------------
// decode_scan
//
// Registered binary-to-one-hot decoder with a built-in scanning index.
// In DECODE mode it behaves like a classic 3-to-8 style decoder delayed by
// one clock. In the scan modes the index walks up or down through every
// output position, advancing once every DIV clocks. A one-cycle pulse marks
// each wrap-around.
//
// Parameters
//   SEL_W : select width, output width is 2**SEL_W (1..6)
//   DIV   : clock cycles per scan step (>= 1)
//
// Ports
//   clk   : single clock, all state changes on its rising edge
//   rst   : synchronous active-high reset, highest priority
//   en    : enable; low zeroes the output, freezes the index, clears
//           the prescaler
//   mode  : 00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
//   load  : one-cycle request to preset the index from 'in'
//   in    : select value (DECODE) or preset value (load)
//   out   : registered one-hot of idx, or all-zero when disabled/reset
//   idx   : registered current index
//   wrap  : registered one-cycle pulse on scan wrap-around
// ---------------------------------------------------------------------------
module decode_scan #(
  parameter int SEL_W = 3,
  parameter int DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      in,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  // A one-bit prescaler is kept even when DIV=1 so the logic has a uniform
  // shape; with DIV=1 the terminal count is 0, so every cycle is a step and
  // the register never leaves 0.
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX  = '1;
  localparam logic [SEL_W-1:0] IDX_ZERO = '0;
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [SEL_W-1:0] idx_q,  idx_d;
  logic [PRE_W-1:0] pre_q,  pre_d;
  logic [OUT_W-1:0] out_q,  out_d;
  logic             wrap_q, wrap_d;

  logic             step;
  logic [PRE_W-1:0] pre_inc;

  assign step    = (pre_q == PRE_LAST);
  assign pre_inc = pre_q + PRE_ONE;

  // Next-state logic. Priority below reset: en=0, then load, then mode.
  // The output is decoded from the *next* index so out and idx always
  // agree in the same cycle.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;

    if (!en) begin
      pre_d = '0;
    end else if (load) begin
      idx_d = in;
      pre_d = '0;
    end else begin
      unique case (mode_s)
        MODE_DECODE: begin
          idx_d = in;
          pre_d = '0;
        end
        MODE_SCAN_UP: begin
          if (step) begin
            idx_d  = idx_q + IDX_ONE;
            pre_d  = '0;
            wrap_d = (idx_q == IDX_MAX);
          end else begin
            pre_d = pre_inc;
          end
        end
        MODE_SCAN_DOWN: begin
          if (step) begin
            idx_d  = idx_q - IDX_ONE;
            pre_d  = '0;
            wrap_d = (idx_q == IDX_ZERO);
          end else begin
            pre_d = pre_inc;
          end
        end
        // HOLD keeps the prescaler phase so a later scan resumes mid-step.
        MODE_HOLD: begin
          idx_d = idx_q;
          pre_d = pre_q;
        end
        default: begin
          idx_d = idx_q;
          pre_d = pre_q;
        end
      endcase
    end

    out_d = en ? (OUT_ONE << idx_d) : '0;
  end

  // State register; reset discards the prescaler phase as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pre_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_scan.sv
// ---------------------------------------------------------------------------
// tb_decode_scan
//
// Drives two decode_scan instances (SEL_W=3, DIV=1 and DIV=3) from shared
// inputs. Each cycle the expected idx/out/wrap of both instances are pushed
// to a queue when inputs are applied and popped after the clock edge.
// Expectations come from hand-written table rows and from a small reference
// model; a randomised run at the end relies on the model alone.
// ---------------------------------------------------------------------------
module tb_decode_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] din;

  logic [7:0] out1, out3;
  logic [2:0] idx1, idx3;
  logic       wrap1, wrap3;

  always #5 clk = ~clk;

  decode_scan #(.SEL_W(3), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(din),
    .out(out1), .idx(idx1), .wrap(wrap1)
  );

  decode_scan #(.SEL_W(3), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(din),
    .out(out3), .idx(idx3), .wrap(wrap3)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] din;
    bit         chk1;
    logic [2:0] idx1;
    logic [7:0] out1;
    logic       wrap1;
    bit         chk3;
    logic [2:0] idx3;
    logic [7:0] out3;
    logic       wrap3;
  } vec_t;

  typedef struct {
    int         dut;
    int         src;
    int         row;
    logic [2:0] idx;
    logic [7:0] out;
    logic       wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t expQ[$];

  int checks   = 0;
  int failures = 0;

  int         mIdx[2];
  int         mPre[2];
  logic [7:0] mOut[2];
  logic       mWrap[2];

  function automatic vec_t mk(
    input logic r, input logic e, input logic [1:0] m, input logic l,
    input logic [2:0] d,
    input bit c1, input logic [2:0] i1, input logic [7:0] o1, input logic w1,
    input bit c3, input logic [2:0] i3, input logic [7:0] o3, input logic w3);
    vec_t v;
    v.rst = r;  v.en = e;  v.mode = m;  v.load = l;  v.din = d;
    v.chk1 = c1; v.idx1 = i1; v.out1 = o1; v.wrap1 = w1;
    v.chk3 = c3; v.idx3 = i3; v.out3 = o3; v.wrap3 = w3;
    return v;
  endfunction

  // Reference behaviour of both instances for the inputs currently driven.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      int div;
      div = (k == 0) ? 1 : 3;
      if (rst) begin
        mIdx[k] = 0; mPre[k] = 0; mWrap[k] = 1'b0;
      end else if (!en) begin
        mPre[k] = 0; mWrap[k] = 1'b0;
      end else if (load || mode == 2'b00) begin
        mIdx[k] = int'(din); mPre[k] = 0; mWrap[k] = 1'b0;
      end else if (mode == 2'b11) begin
        mWrap[k] = 1'b0;
      end else begin
        mWrap[k] = 1'b0;
        if (mPre[k] == div - 1) begin
          mPre[k] = 0;
          if (mode == 2'b01) begin
            mWrap[k] = (mIdx[k] == 7);
            mIdx[k]  = (mIdx[k] + 1) % 8;
          end else begin
            mWrap[k] = (mIdx[k] == 0);
            mIdx[k]  = (mIdx[k] + 7) % 8;
          end
        end else begin
          mPre[k] = mPre[k] + 1;
        end
      end
      mOut[k] = (!rst && en) ? 8'(1 << mIdx[k]) : 8'h00;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int rowId);
    exp_t e;
    rst  = v.rst;
    en   = v.en;
    mode = v.mode;
    load = v.load;
    din  = v.din;
    modelStep();
    for (int k = 0; k < 2; k++) begin
      e.dut = k; e.src = 0; e.row = rowId;
      e.idx = 3'(mIdx[k]); e.out = mOut[k]; e.wrap = mWrap[k];
      expQ.push_back(e);
    end
    if (v.chk1) begin
      e.dut = 0; e.src = 1; e.row = rowId;
      e.idx = v.idx1; e.out = v.out1; e.wrap = v.wrap1;
      expQ.push_back(e);
    end
    if (v.chk3) begin
      e.dut = 1; e.src = 1; e.row = rowId;
      e.idx = v.idx3; e.out = v.out3; e.wrap = v.wrap3;
      expQ.push_back(e);
    end
  endtask

  task automatic compareField(input string fieldName, input exp_t e,
                              input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s_%s div%0d row%0d: got %0h required %0h",
               (e.src == 1) ? "table" : "model", fieldName,
               (e.dut == 1) ? 3 : 1, e.row, got, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.dut == 0) begin
        compareField("idx",  e, {5'b0, idx1},  {5'b0, e.idx});
        compareField("out",  e, out1,          e.out);
        compareField("wrap", e, {7'b0, wrap1}, {7'b0, e.wrap});
      end else begin
        compareField("idx",  e, {5'b0, idx3},  {5'b0, e.idx});
        compareField("out",  e, out3,          e.out);
        compareField("wrap", e, {7'b0, wrap3}, {7'b0, e.wrap});
      end
    end
  endtask

  task automatic runVec(input vec_t v, input int rowId);
    @(negedge clk);
    applyStimulus(v, rowId);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; din = 3'd0;
    mIdx = '{0, 0}; mPre = '{0, 0};

    //          rst en  mode  ld  in     c1 idx1 out1   w1     c3 idx3 out3   w3
    // Reset, including rst winning over en/load
    tbl.push_back(mk(1, 0, 2'b00, 0, 3'd0, 1, 3'd0, 8'h00, 0, 1, 3'd0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 3'd5, 1, 3'd0, 8'h00, 0, 1, 3'd0, 8'h00, 0));
    // Legacy decode, then en=0 gating (in ignored)
    tbl.push_back(mk(0, 1, 2'b00, 0, 3'd5, 1, 3'd5, 8'h20, 0, 1, 3'd5, 8'h20, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 3'd2, 1, 3'd5, 8'h00, 0, 1, 3'd5, 8'h00, 0));
    // Scan-up wrap: load 6, then three scan-up cycles
    tbl.push_back(mk(0, 1, 2'b00, 1, 3'd6, 1, 3'd6, 8'h40, 0, 1, 3'd6, 8'h40, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd7, 8'h80, 0, 1, 3'd6, 8'h40, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd0, 8'h01, 1, 1, 3'd6, 8'h40, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd1, 8'h02, 0, 1, 3'd7, 8'h80, 0));
    // Scan-down wrap: load 1, then three scan-down cycles
    tbl.push_back(mk(0, 1, 2'b10, 1, 3'd1, 1, 3'd1, 8'h02, 0, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b10, 0, 3'd0, 1, 3'd0, 8'h01, 0, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b10, 0, 3'd0, 1, 3'd7, 8'h80, 1, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b10, 0, 3'd0, 1, 3'd6, 8'h40, 0, 1, 3'd0, 8'h01, 0));
    // Priorities: reach idx 4 scanning up, load 2, then rst with en+load
    tbl.push_back(mk(0, 1, 2'b00, 1, 3'd3, 1, 3'd3, 8'h08, 0, 1, 3'd3, 8'h08, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd4, 8'h10, 0, 1, 3'd3, 8'h08, 0));
    tbl.push_back(mk(0, 1, 2'b01, 1, 3'd2, 1, 3'd2, 8'h04, 0, 1, 3'd2, 8'h04, 0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 3'd5, 1, 3'd0, 8'h00, 0, 1, 3'd0, 8'h00, 0));
    // Prescaler: load 0 then scan up; DIV=3 steps every third edge
    tbl.push_back(mk(0, 1, 2'b01, 1, 3'd0, 1, 3'd0, 8'h01, 0, 1, 3'd0, 8'h01, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd1, 8'h02, 0, 1, 3'd0, 8'h01, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd2, 8'h04, 0, 1, 3'd0, 8'h01, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd3, 8'h08, 0, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd4, 8'h10, 0, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd5, 8'h20, 0, 1, 3'd1, 8'h02, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd6, 8'h40, 0, 1, 3'd2, 8'h04, 0));
    // HOLD mid-step: DIV=3 at pre=1, hold 5 cycles, step on 2nd edge after
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd7, 8'h80, 0, 1, 3'd2, 8'h04, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 2'b11, 0, 3'd5, 1, 3'd7, 8'h80, 0, 1, 3'd2, 8'h04, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd0, 8'h01, 1, 1, 3'd2, 8'h04, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd1, 8'h02, 0, 1, 3'd3, 8'h08, 0));
    // en=0 clears the prescaler phase: next DIV=3 step needs 3 full edges
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd2, 8'h04, 0, 1, 3'd3, 8'h08, 0));
    tbl.push_back(mk(0, 0, 2'b01, 1, 3'd6, 1, 3'd2, 8'h00, 0, 1, 3'd3, 8'h00, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd3, 8'h08, 0, 1, 3'd3, 8'h08, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd4, 8'h10, 0, 1, 3'd3, 8'h08, 0));
    tbl.push_back(mk(0, 1, 2'b01, 0, 3'd0, 1, 3'd5, 8'h20, 0, 1, 3'd4, 8'h10, 0));

    $display("[TB] applying %0d table rows", tbl.size());
    foreach (tbl[i]) runVec(tbl[i], i);

    // Randomised traffic checked against the reference model only.
    $display("[TB] applying random traffic");
    for (int i = 0; i < 400; i++) begin
      v = mk(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) != 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
             3'($urandom_range(0, 7)),
             0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
      runVec(v, 1000 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_scan.md
DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width; output width is 2**SEL_W; legal range 1..6.
REQ-002 SHALL have parameter DIV, default 1: clock cycles per scan step; legal range >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  enable; low forces the output to zero and freezes the index.
REQ-006 SHALL have port mode  input  2  mode: 00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-007 SHALL have port load  input  1  one-cycle request to preset the index from in.
REQ-008 SHALL have port in  input  SEL_W  select value or preset value.
REQ-009 SHALL have port out  output  2**SEL_W  registered one-hot (or all-zero) decoded output.
REQ-010 SHALL have port idx  output  SEL_W  registered current index.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-012 SHALL hold internal state: index register idx, prescaler pre counting 0..DIV-1; when DIV=1, pre is constant 0.
REQ-013 SHALL, at every edge with rst=0, update out so that out == (en ? onehot(idx_new) : 0), where idx_new is the value idx takes at that same edge; latency is 1 cycle from inputs to out.
REQ-014 SHALL, with en=0: hold idx; clear pre, out and wrap; ignore load, mode and in.
REQ-015 SHALL, with en=1 and load=1, regardless of mode: set idx<=in, pre<=0, wrap<=0.
REQ-016 SHALL, in DECODE (en=1, load=0): set idx<=in every cycle, pre<=0, wrap<=0; this matches the legacy 3-to-8 decoder behaviour, delayed by one clock.
REQ-017 SHALL, in SCAN_UP (en=1, load=0): when pre==DIV-1, set idx<=idx+1 modulo 2**SEL_W and pre<=0, else set pre<=pre+1; wrap<=1 only on a step where the old idx was 2**SEL_W-1, otherwise wrap<=0.
REQ-018 SHALL, in SCAN_DOWN (en=1, load=0): when pre==DIV-1, set idx<=idx-1 modulo 2**SEL_W and pre<=0, else set pre<=pre+1; wrap<=1 only on a step where the old idx was 0, otherwise wrap<=0.
REQ-019 SHALL, in HOLD (en=1, load=0): keep idx and pre unchanged, set wrap<=0, and keep out at onehot(idx).
REQ-020 SHALL carry pre unchanged across direct switches between SCAN_UP, SCAN_DOWN and HOLD; only DECODE, load, en=0 or rst clear it.
REQ-021 SHALL assert wrap for exactly one cycle per wrap event; with DIV=1 and continuous scan, wrap pulses once every 2**SEL_W cycles.
REQ-022 SHALL, whenever en=1 after an edge, have out with exactly one bit set, at position idx.
REQ-023 SHALL contain no combinational path from any input to out, idx or wrap.
REQ-024 SHALL give rst priority over load, en and mode.

Reset
REQ-025 SHALL, at an edge with rst=1: set idx=0, pre=0, out=0 and wrap=0; rst asserted mid-scan discards the prescaler phase.
REQ-026 SHALL, on the first edge after rst deasserts with en=1, produce out=onehot(updated idx) per REQ-013..REQ-019.

Verification
REQ-027 SHALL verify legacy decode: SEL_W=3, en=1, mode=00, in=3'b101 -> one edge later out=8'h20, idx=5; then en=0 -> one edge later out=8'h00, idx=5.
REQ-028 SHALL verify scan-up wrap: SEL_W=3, DIV=1, load in=6, then mode=01 for 3 cycles -> idx 7,0,1, with out 8'h80,8'h01,8'h02 and wrap=1 only in the cycle idx=0.
REQ-029 SHALL verify the prescaler: SEL_W=3, DIV=3, load in=0, mode=01 -> idx steps at every third edge: 0,0,1,1,1,2, with out stable between steps.
REQ-030 SHALL verify scan-down wrap: SEL_W=3, DIV=1, load in=1, mode=10 -> idx 0,7,6, with wrap=1 only in the cycle idx=7.
REQ-031 SHALL verify priorities: during SCAN_UP at idx=4 assert load with in=2 -> idx=2, wrap=0; then, at any state, assert rst with en=1 and load=1 -> idx=0, out=0, wrap=0.
REQ-032 SHALL verify HOLD and en gating: DIV=3, mode=01 at pre=1, then mode=11 for 5 cycles, then mode=01 -> idx holds during HOLD and the step occurs at the 2nd edge after resuming.
